plusarg_progress_watchdog: RTL
==============================

Name: plusarg_progress_watchdog

Overview:
- Cycle-count watchdog placed directly downstream of the harness plusarg reader.
- Its `limit` input is driven by the reader's `out`, e.g. a `+max_core_cycles=` / `+watchdog_timeout=` style value.
- Counts consecutive cycles without a `progress` pulse. Flags a timeout when that run reaches `limit`; the harness success/fail logic uses the flag to stop the simulation.
- A `limit` of 0, which is the plusarg default, disables the watchdog.

Parameters:
- WIDTH, 32, bit width of `limit` and the internal cycle counter. Must match the reader's WIDTH.

Ports:
- clock     input   1      sole clock; all state updates on its rising edge
- reset_n   input   1      asynchronous, active-low reset
- limit     input   WIDTH  timeout threshold from the plusarg reader; quasi-static; 0 = disabled
- enable    input   1      arms the watchdog (e.g. deasserted until the DUT leaves reset)
- progress  input   1      forward-progress indication (e.g. instruction retire); any high cycle restarts the count
- clear     input   1      synchronous clear of the expired condition and the counter
- count     output  WIDTH  current consecutive-no-progress cycle count
- timeout   output  1      single-cycle registered pulse on entry to EXPIRED
- expired   output  1      sticky level; high while in EXPIRED

Behaviour:
- Reset (reset_n low, asynchronous):
  - state = IDLE, count = 0, timeout = 0, expired = 0.
  - Reset release is not required to be synchronous to clock.
  - Reset asserted mid-count or in EXPIRED returns everything to these values immediately.
- Armed condition: `armed = enable && (limit != 0)`, evaluated each cycle.
- State IDLE:
  - count held at 0.
  - If armed: go to COUNTING on the next edge; count stays 0 on that edge.
- State COUNTING, priority per edge:
  1. `clear` → IDLE, count = 0.
  2. not armed → IDLE, count = 0.
  3. `progress` → count = 0, stay in COUNTING.
  4. `count + 1 >= limit` → EXPIRED, count = limit, timeout = 1 for exactly the following cycle.
  5. otherwise count = count + 1.
- Compare width:
  - The comparison in COUNTING is done in WIDTH+1 bits, so `count + 1` never wraps.
  - count never exceeds limit and never wraps.
- Latency:
  - From the edge that enters COUNTING with count = 0, N consecutive no-progress edges with limit = N make expired high after the Nth edge.
  - timeout is high during the cycle following that edge.
- State EXPIRED:
  - expired = 1; count frozen.
  - progress, enable and limit changes are ignored.
  - Only `clear` (→ IDLE, count = 0, expired = 0 on that edge) or reset leaves EXPIRED.
- timeout is a registered pulse: 1 only in the first cycle of EXPIRED, 0 in every other cycle.
- Limit change mid-count:
  - If the new limit ≤ count + 1, expiry occurs on the next edge, unless progress is high that cycle.
  - Changing limit to 0 returns to IDLE (rule 2).
- Simultaneous events:
  - clear beats progress and expiry.
  - progress beats expiry: progress on the cycle count + 1 == limit keeps COUNTING with count = 0.
- No combinational path from any input to any output; all outputs are registers or a decode of registered state.
- No X on outputs after reset regardless of input X.

Test Plan:
- Reset values: reset_n = 0, enable = 1, limit = 5 → count = 0, timeout = 0, expired = 0. After release with no progress, expired rises 5 edges after COUNTING entry, count = 5, timeout high for one cycle only.
- Disabled: limit = 0, enable = 1, no progress for 1000 cycles → state IDLE, count = 0, expired never asserts.
- Progress restarts the count: limit = 4; progress pulses every 3rd cycle for 50 cycles → count cycles 0, 1, 2, 0…, expired stays 0. Stop progress → expired 4 edges after the last progress.
- Boundary priority: limit = 3; progress asserted exactly on the cycle count = 2 → no expiry, count = 0. Clear asserted on the cycle count = 2 without progress → IDLE, expired stays 0.
- Sticky and clear: expire with limit = 2, then toggle progress and enable and set limit = 0 → expired stays 1, count frozen at 2. Pulse clear → expired = 0, count = 0 next cycle. Re-arm → expires again after 2 cycles.
- Asynchronous reset mid-operation:
  - Assert reset_n low between clock edges while count = 7 of limit = 10 → outputs reach reset values without a clock edge.
  - Assert it in EXPIRED → expired drops immediately, and timeout is not re-pulsed after release.

Source files
------------

// File: rtl/plusarg_progress_watchdog.sv
// Cycle-count watchdog: flags a timeout when `limit` consecutive cycles pass without progress.
// A zero limit (plusarg default) or a low enable keeps it idle.
module plusarg_progress_watchdog #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] limit,
    input  logic             enable,
    input  logic             progress,
    input  logic             clear,
    output logic [WIDTH-1:0] count,
    output logic             timeout,
    output logic             expired
);

    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] COUNTING = 2'd1;
    localparam logic [1:0] EXPIRED  = 2'd2;

    logic [1:0]       state, state_nxt;
    logic [WIDTH-1:0] count_nxt;
    logic             timeout_nxt;
    logic             armed;
    logic [WIDTH:0]   count_inc;

    assign armed = enable && (limit != '0);
    // One extra bit so count + 1 cannot wrap before the compare.
    assign count_inc = {1'b0, count} + {{WIDTH{1'b0}}, 1'b1};

    always_comb begin
        state_nxt   = state;
        count_nxt   = count;
        timeout_nxt = 1'b0;
        case (state)
            IDLE: begin
                count_nxt = '0;
                if (!clear && armed) state_nxt = COUNTING;
            end
            COUNTING: begin
                if (clear || !armed) begin
                    state_nxt = IDLE;
                    count_nxt = '0;
                end else if (progress) begin
                    count_nxt = '0;
                end else if (count_inc >= {1'b0, limit}) begin
                    state_nxt   = EXPIRED;
                    count_nxt   = limit;
                    timeout_nxt = 1'b1;
                end else begin
                    count_nxt = count_inc[WIDTH-1:0];
                end
            end
            EXPIRED: begin
                if (clear) begin
                    state_nxt = IDLE;
                    count_nxt = '0;
                end
            end
            default: begin
                state_nxt = IDLE;
                count_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            count   <= '0;
            timeout <= 1'b0;
        end else begin
            state   <= state_nxt;
            count   <= count_nxt;
            timeout <= timeout_nxt;
        end
    end

    assign expired = (state == EXPIRED);

endmodule
